// File: rtl/digit_serial_addsub.sv
// Digit-serial N-bit adder/subtractor: D bits per cycle, LSB digit first,
// with a registered inter-digit carry and valid/ready on both sides.
module digit_serial_addsub #(
  parameter int N = 32,
  parameter int D = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  input  logic         Cin,
  input  logic         sub,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] Sum,
  output logic         Cout,
  output logic         Ovf
);

  localparam int K  = N / D;
  localparam int CW = (K > 1) ? $clog2(K) : 1;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  state_t         r_state;
  state_t         w_next;
  logic [CW-1:0]  r_cnt;
  logic [N-1:0]   r_a;
  logic [N-1:0]   r_b;
  logic [N-1:0]   r_res;
  logic           r_c;

  int             w_base;
  logic [D-1:0]   w_ad;
  logic [D-1:0]   w_bd;
  logic [D-1:0]   w_sd;
  logic [D:0]     w_ext;
  logic           w_co;
  logic           w_cmsb;
  logic           w_last;
  logic [N-1:0]   w_res;

  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == DONE);

  always_comb begin
    w_base = int'(r_cnt) * D;
    w_ad   = r_a[w_base +: D];
    w_bd   = r_b[w_base +: D];
    w_ext  = {1'b0, w_ad} + {1'b0, w_bd} + {{D{1'b0}}, r_c};
    w_sd   = w_ext[D-1:0];
    w_co   = w_ext[D];
    // Carry into the digit's top bit, recovered from its sum bit.
    w_cmsb = w_ad[D-1] ^ w_bd[D-1] ^ w_sd[D-1];
    w_last = (r_cnt == CW'(K - 1));
    w_res  = r_res;
    w_res[w_base +: D] = w_sd;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    if (in_valid) w_next = BUSY;
      BUSY:    if (w_last) w_next = DONE;
      DONE:    if (out_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt <= '0;
      r_c   <= 1'b0;
      Sum   <= '0;
      Cout  <= 1'b0;
      Ovf   <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_a   <= A;
            r_b   <= sub ? ~B : B;
            r_c   <= sub | Cin;
            r_cnt <= '0;
          end
        end
        BUSY: begin
          r_res <= w_res;
          r_c   <= w_co;
          r_cnt <= r_cnt + CW'(1);
          if (w_last) begin
            Sum  <= w_res;
            Cout <= w_co;
            Ovf  <= w_cmsb ^ w_co;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_digit_serial_addsub.sv
// Directed bench for digit_serial_addsub: 32/8, 8/8 and 8/1 configurations.
// Checks results, latency, handshakes, backpressure and mid-operation reset.
module tb_digit_serial_addsub;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        iv, ir, cin, sb, ov, ordy, cout, ovf;
  logic [31:0] a, b, sum;

  logic       iv8[2], ir8[2], cin8[2], sb8[2];
  logic       ov8[2], ordy8[2], cout8[2], ovf8[2];
  logic [7:0] a8[2], b8[2], sum8[2];

  int checks = 0;
  int failures = 0;
  logic [31:0] exp_prev = '0;

  digit_serial_addsub #(.N(32), .D(8)) u32 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv), .in_ready(ir),
    .A(a), .B(b), .Cin(cin), .sub(sb), .out_valid(ov),
    .out_ready(ordy), .Sum(sum), .Cout(cout), .Ovf(ovf)
  );

  digit_serial_addsub #(.N(8), .D(8)) u88 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv8[0]), .in_ready(ir8[0]),
    .A(a8[0]), .B(b8[0]), .Cin(cin8[0]), .sub(sb8[0]),
    .out_valid(ov8[0]), .out_ready(ordy8[0]), .Sum(sum8[0]),
    .Cout(cout8[0]), .Ovf(ovf8[0])
  );

  digit_serial_addsub #(.N(8), .D(1)) u81 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv8[1]), .in_ready(ir8[1]),
    .A(a8[1]), .B(b8[1]), .Cin(cin8[1]), .sub(sb8[1]),
    .out_valid(ov8[1]), .out_ready(ordy8[1]), .Sum(sum8[1]),
    .Cout(cout8[1]), .Ovf(ovf8[1])
  );

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic op32(input string tag, input logic [31:0] ta,
                      input logic [31:0] tb, input logic tc,
                      input logic ts, input logic [31:0] es,
                      input logic ec, input logic eo);
    int n;
    n = 0;
    while (!ir && n < 50) begin
      step();
      n++;
    end
    chk({tag, "_rdy"}, ir, 1'b1);
    iv = 1'b1; a = ta; b = tb; cin = tc; sb = ts;
    step();
    iv = 1'b0;
    a = $urandom; b = $urandom; cin = ~tc; sb = ~ts;
    chk({tag, "_busy_rdy"}, ir, 1'b0);
    chk({tag, "_hold"}, sum, exp_prev);
    n = 0;
    while (!ov && n < 40) begin
      step();
      n++;
    end
    chk({tag, "_lat"}, n, 4);
    chk({tag, "_sum"}, sum, es);
    chk({tag, "_cout"}, cout, ec);
    chk({tag, "_ovf"}, ovf, eo);
    chk({tag, "_done_rdy"}, ir, 1'b0);
    exp_prev = es;
  endtask

  task automatic drain32(input string tag);
    ordy = 1'b1;
    step();
    ordy = 1'b0;
    chk({tag, "_ov_low"}, ov, 1'b0);
    chk({tag, "_idle_rdy"}, ir, 1'b1);
  endtask

  task automatic op8(input int w, input string tag,
                     input logic [7:0] ta, input logic [7:0] tb,
                     input logic tc, input logic ts,
                     input logic [7:0] es, input logic ec,
                     input logic eo, input int elat);
    int n;
    chk({tag, "_rdy"}, ir8[w], 1'b1);
    iv8[w] = 1'b1; a8[w] = ta; b8[w] = tb; cin8[w] = tc; sb8[w] = ts;
    step();
    iv8[w] = 1'b0;
    a8[w] = 8'h5A; b8[w] = 8'hA5; cin8[w] = ~tc; sb8[w] = ~ts;
    n = 0;
    while (!ov8[w] && n < 40) begin
      step();
      n++;
    end
    chk({tag, "_lat"}, n, elat);
    chk({tag, "_sum"}, sum8[w], es);
    chk({tag, "_cout"}, cout8[w], ec);
    chk({tag, "_ovf"}, ovf8[w], eo);
    ordy8[w] = 1'b1;
    step();
    ordy8[w] = 1'b0;
    chk({tag, "_idle"}, ir8[w], 1'b1);
  endtask

  initial begin
    iv = 0; a = '0; b = '0; cin = 0; sb = 0; ordy = 0;
    for (int i = 0; i < 2; i++) begin
      iv8[i] = 0; a8[i] = '0; b8[i] = '0;
      cin8[i] = 0; sb8[i] = 0; ordy8[i] = 0;
    end
    rst_n = 1'b0;
    step();
    step();
    chk("rst_rdy", ir, 1'b1);
    chk("rst_ov", ov, 1'b0);
    chk("rst_sum", sum, 32'h0);
    chk("rst_cout", cout, 1'b0);
    chk("rst_ovf", ovf, 1'b0);
    rst_n = 1'b1;
    step();

    op32("add_wrap", 32'hFFFFFFFF, 32'h1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
    drain32("add_wrap");
    op32("sub_5_7", 32'd5, 32'd7, 1'b0, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0);
    drain32("sub_5_7");
    op32("sub_7_5", 32'd7, 32'd5, 1'b1, 1'b1, 32'h2, 1'b1, 1'b0);
    drain32("sub_7_5");
    op32("sub_neg", 32'h80000000, 32'h1, 1'b0, 1'b1,
         32'h7FFFFFFF, 1'b1, 1'b1);
    drain32("sub_neg");
    op32("add_cin", 32'h12345678, 32'h11111111, 1'b1, 1'b0,
         32'h2345678A, 1'b0, 1'b0);
    drain32("add_cin");
    op32("add_ovf", 32'h7FFFFFFF, 32'h1, 1'b0, 1'b0,
         32'h80000000, 1'b0, 1'b1);

    for (int i = 0; i < 6; i++) begin
      iv = (i % 2 == 0);
      a = $urandom; b = $urandom; cin = 1'b1; sb = 1'b0;
      step();
      chk("bp_ov", ov, 1'b1);
      chk("bp_sum", sum, 32'h80000000);
      chk("bp_flags", {cout, ovf}, 2'b01);
    end
    iv = 1'b0;
    drain32("bp");
    chk("bp_sum_idle", sum, 32'h80000000);

    iv = 1'b1; a = 32'h11111111; b = 32'h1; cin = 0; sb = 0;
    step();
    iv = 1'b0;
    step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("mrst_ov", ov, 1'b0);
    chk("mrst_rdy", ir, 1'b1);
    chk("mrst_sum", sum, 32'h0);
    chk("mrst_flags", {cout, ovf}, 2'b00);
    exp_prev = '0;
    for (int i = 0; i < 6; i++) begin
      step();
      chk("mrst_no_ov", ov, 1'b0);
    end
    op32("add_3_4", 32'd3, 32'd4, 1'b0, 1'b0, 32'd7, 1'b0, 1'b0);
    drain32("add_3_4");

    op8(0, "k1_add", 8'hF0, 8'h20, 1'b0, 1'b0, 8'h10, 1'b1, 1'b0, 1);
    op8(1, "k8_sub", 8'h00, 8'h01, 1'b0, 1'b1, 8'hFF, 1'b0, 1'b0, 8);
    op8(1, "k8_ovf", 8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1, 8);
    op8(1, "k8_cin", 8'hA5, 8'h5A, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 8);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/digit_serial_addsub.md
Name: digit_serial_addsub

Overview:
- Parametrised, sequential successor to the team's combinational N-bit ripple-carry adder.
- Adds or subtracts two N-bit operands D bits per clock, LSB digit first, through a single D-bit full-adder chain.
- A registered carry links each digit to the next.
- Valid/ready handshakes on input and output let it sit between datapath stages where area matters more than latency.
- Also reports carry-out and signed overflow.

Parameters:
- N, 32, operand/result width in bits (N >= 2).
- D, 8, digit width processed per cycle. N mod D must be 0; 1 <= D <= N; K = N/D cycles per operation.

Ports:
- clk  input  1  rising-edge clock, sole clock.
- rst_n  input  1  synchronous active-low reset.
- in_valid  input  1  operands/mode valid.
- in_ready  output  1  block can accept an operation.
- A  input  N  operand A.
- B  input  N  operand B.
- Cin  input  1  carry-in, add mode only.
- sub  input  1  0: A+B+Cin; 1: A-B (Cin ignored).
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- Sum  output  N  result.
- Cout  output  1  carry out of bit N-1 (sub: 1 = no borrow).
- Ovf  output  1  two's-complement signed overflow.

Behaviour:
- Reset and clock: single clock, clk; reset is synchronous and active-low, rst_n.
- While rst_n=0 at a rising edge:
  - state <- IDLE, digit counter <- 0, internal carry <- 0.
  - Sum <- 0, Cout <- 0, Ovf <- 0, out_valid <- 0.
  - in_valid is ignored.
- States: IDLE, BUSY, DONE.
- in_ready = (state==IDLE). out_valid = (state==DONE). Both are decoded from registered state only, with no combinational path from in_valid or out_ready.
- IDLE:
  - Stays in IDLE until in_valid & in_ready at an edge (the acceptance edge).
  - On acceptance, latch A; latch B, or ~B when sub=1.
  - On acceptance, latch carry-in: Cin when sub=0, 1 when sub=1.
  - Counter <- 0; go to BUSY.
- BUSY:
  - Each edge adds digit i (bits i*D+D-1 : i*D) of the latched operands with the registered carry.
  - Writes the D-bit digit sum into the internal result shift register and updates the carry register.
  - Counter increments; on the edge that processes digit K-1, go to DONE.
  - On that edge, load Sum/Cout/Ovf from the completed result.
- Latency: out_valid rises exactly K edges after the acceptance edge. With D=N, out_valid rises 1 edge after acceptance.
- Sum/Cout/Ovf change only on the BUSY->DONE edge and on reset. Otherwise they hold the last result, including through IDLE and BUSY of the next operation.
- Ovf = carry into bit N-1 XOR carry out of bit N-1, both computed on the final digit.
- DONE: outputs held stable while out_ready=0, for unbounded backpressure. At an edge with out_ready=1, go to IDLE.
- Throughput: one operation per K+2 cycles minimum. There is no overlap: an operation can be accepted only in IDLE, never in the DONE->IDLE cycle.
- in_valid while BUSY or DONE: ignored; operands are not sampled.
- Mid-operation changes: A/B/Cin/sub may change after acceptance without affecting the result in flight.
- Reset mid-BUSY or mid-DONE: operation discarded, outputs cleared per the reset values, no out_valid pulse. The next accepted operation computes correctly.
- All arithmetic is modulo 2^N. Carry never propagates between operations.

Test Plan:
- N=32,D=8, add A=0xFFFFFFFF, B=0x00000001, Cin=0 -> Sum=0x00000000, Cout=1, Ovf=0; out_valid rises 4 edges after acceptance; in_ready=0 until the DONE handshake.
- Sub A=5, B=7 -> Sum=0xFFFFFFFE, Cout=0, Ovf=0. Sub A=7, B=5 -> Sum=0x00000002, Cout=1, Ovf=0.
- Overflow:
  - Add A=0x7FFFFFFF, B=1, Cin=0 -> Sum=0x80000000, Cout=0, Ovf=1.
  - Sub A=0x80000000, B=1 -> Sum=0x7FFFFFFF, Cout=1, Ovf=1.
  - Add A=0x12345678, B=0x11111111, Cin=1 -> Sum=0x2345678A, Ovf=0.
- Backpressure: hold out_ready=0 for 6 cycles in DONE while pulsing in_valid with new operands -> out_valid stays 1, Sum/Cout/Ovf unchanged, no acceptance. Raise out_ready -> IDLE next edge, in_ready=1.
- Reset: drive rst_n=0 for one edge at the 2nd BUSY cycle -> state IDLE, out_valid=0, Sum=0, Cout=0, Ovf=0. A fresh add 3+4 then yields Sum=7 after 4 edges.
- Config N=8,D=8 (K=1): add 0xF0+0x20 -> Sum=0x10, Cout=1, Ovf=0, out_valid 1 edge after acceptance.
- Config N=8,D=1 (K=8): sub 0x00-0x01 -> Sum=0xFF, Cout=0, Ovf=0 after 8 edges.
